pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline stage register; successor to the fixed-field inter-stage latches (e.g. M/W).
- Carries one opaque payload of DATA_W bits with valid/ready handshake and a 2-entry skid buffer, so backpressure never drops or duplicates instructions.
- Provides flush (IRQ/branch squash) and optional zeroing of payload to a NOP.
- Instanced between every pair of CPU pipeline stages; the payload is the concatenation of that stage's fields (Instr, ALU out, DM data, WriteReg, PC4, ...).

---
 rtl/pipe_stage_reg_if.sv | 14 +
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one side of an elastic pipeline stage.
// A beat transfers on a rising edge where valid and ready are both 1. Once valid is
// raised, the sender holds valid and data steady until that edge. ready may change
// freely and must not depend combinationally on valid.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: a main register plus a one-entry skid buffer, with a
// squash input. All outputs come straight from flops, so backpressure never crosses the stage.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W         = 32,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL      = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  pipe_stage_reg_if.slave       up,
  pipe_stage_reg_if.master      dn,
  output logic [1:0]            occupancy
);

  // The state encoding is the entry count, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = up.valid & in_ready;
  assign out_fire  = out_valid & dn.ready;

  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;
  assign dn.data   = main_q;
  assign occupancy = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // An accepted input beat in this cycle is deliberately dropped.
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = up.data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_fire, out_fire})
            2'b11: main_d = up.data;
            2'b01: state_d = ST_EMPTY;
            2'b10: begin
              skid_d  = up.data;
              state_d = ST_TWO;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed checks on two 32-bit variants sharing one stimulus,
// then random traffic on 1-bit and 170-bit variants against expected queues.
module tb_pipe_stage_reg;

  logic clk;
  logic reset;
  logic flush;
  int   n_tests;
  int   n_fail;

  logic [1:0] occ_a, occ_b, occ_c, occ_d;

  pipe_stage_reg_if #(.DATA_W(32))  a_up ();
  pipe_stage_reg_if #(.DATA_W(32))  a_dn ();
  pipe_stage_reg_if #(.DATA_W(32))  b_up ();
  pipe_stage_reg_if #(.DATA_W(32))  b_dn ();
  pipe_stage_reg_if #(.DATA_W(1))   c_up ();
  pipe_stage_reg_if #(.DATA_W(1))   c_dn ();
  pipe_stage_reg_if #(.DATA_W(170)) d_up ();
  pipe_stage_reg_if #(.DATA_W(170)) d_dn ();

  // Variant B mirrors A's stimulus.
  assign b_up.valid = a_up.valid;
  assign b_up.data  = a_up.data;
  assign b_dn.ready = a_dn.ready;

  pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b1), .RESET_VAL(32'h0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .up(a_up), .dn(a_dn), .occupancy(occ_a));
  pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b0), .RESET_VAL(32'h12345678)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .up(b_up), .dn(b_dn), .occupancy(occ_b));
  pipe_stage_reg #(.DATA_W(1)) dut_c (
    .clk(clk), .reset(reset), .flush(1'b0), .up(c_up), .dn(c_dn), .occupancy(occ_c));
  pipe_stage_reg #(.DATA_W(170)) dut_d (
    .clk(clk), .reset(reset), .flush(1'b0), .up(d_up), .dn(d_dn), .occupancy(occ_d));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [0:0]   exp_c[$];
  logic [169:0] exp_d[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic r);
    a_up.valid = v;
    a_up.data  = d;
    a_dn.ready = r;
  endtask

  task automatic random_traffic(input int cycles, input bit drain);
    for (int i = 0; i < cycles; i++) begin
      step();
      check("c_occ", {254'd0, occ_c}, exp_c.size());
      check("d_occ", {254'd0, occ_d}, exp_d.size());
      if (drain) begin
        c_up.valid = 1'b0;
        d_up.valid = 1'b0;
        c_dn.ready = 1'b1;
        d_dn.ready = 1'b1;
      end else begin
        c_up.valid = 1'($urandom_range(0, 1));
        c_up.data  = 1'($urandom_range(0, 1));
        c_dn.ready = 1'($urandom_range(0, 1));
        d_up.valid = 1'($urandom_range(0, 1));
        d_up.data  = {$urandom, $urandom, $urandom, $urandom, $urandom, 10'($urandom)};
        d_dn.ready = 1'($urandom_range(0, 1));
      end
      #4;
      if (c_dn.valid && c_dn.ready) begin
        if (exp_c.size() == 0) check("c_dup", {255'd0, c_dn.valid}, 256'd0);
        else check("c_data", {255'd0, c_dn.data}, {255'd0, exp_c.pop_front()});
      end
      if (c_up.valid && c_up.ready) exp_c.push_back(c_up.data);
      if (d_dn.valid && d_dn.ready) begin
        if (exp_d.size() == 0) check("d_dup", {255'd0, d_dn.valid}, 256'd0);
        else check("d_data", {86'd0, d_dn.data}, {86'd0, exp_d.pop_front()});
      end
      if (d_up.valid && d_up.ready) exp_d.push_back(d_up.data);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    flush = 1'b0;
    drive_a(1'b1, 32'hDEADBEEF, 1'b0);
    c_up.valid = 1'b0; c_up.data = 1'b0; c_dn.ready = 1'b0;
    d_up.valid = 1'b0; d_up.data = '0;   d_dn.ready = 1'b0;

    // reset with a pending input: nothing captured
    step();
    step();
    check("rst_valid", {255'd0, a_dn.valid}, 256'd0);
    check("rst_occ", {254'd0, occ_a}, 256'd0);
    check("rst_ready", {255'd0, a_up.ready}, 256'd1);
    check("rst_data_a", {224'd0, a_dn.data}, 256'h0);
    check("rst_data_b", {224'd0, b_dn.data}, 256'h12345678);
    reset = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0);
    step();
    check("rst_hold_valid", {255'd0, a_dn.valid}, 256'd0);

    // streaming, one beat per cycle
    drive_a(1'b1, 32'h1, 1'b1);
    step();
    check("str_data1", {224'd0, a_dn.data}, 256'h1);
    check("str_valid1", {255'd0, a_dn.valid}, 256'd1);
    drive_a(1'b1, 32'h2, 1'b1);
    step();
    check("str_data2", {224'd0, a_dn.data}, 256'h2);
    check("str_occ2", {254'd0, occ_a}, 256'd1);
    drive_a(1'b1, 32'h3, 1'b1);
    step();
    check("str_data3", {224'd0, a_dn.data}, 256'h3);
    check("str_valid3", {255'd0, a_dn.valid}, 256'd1);
    drive_a(1'b0, 32'h0, 1'b1);
    step();
    check("str_empty", {255'd0, a_dn.valid}, 256'd0);
    check("str_hold", {224'd0, a_dn.data}, 256'h3);

    // backpressure fills the skid buffer
    drive_a(1'b1, 32'hA, 1'b0);
    step();
    check("bp_occ1", {254'd0, occ_a}, 256'd1);
    drive_a(1'b1, 32'hB, 1'b0);
    step();
    check("bp_occ2", {254'd0, occ_a}, 256'd2);
    check("bp_ready0", {255'd0, a_up.ready}, 256'd0);
    check("bp_dataA", {224'd0, a_dn.data}, 256'hA);
    drive_a(1'b1, 32'hEE, 1'b0);
    step();
    check("bp_stableA", {224'd0, a_dn.data}, 256'hA);
    check("bp_occ2b", {254'd0, occ_a}, 256'd2);
    drive_a(1'b0, 32'h0, 1'b1);
    step();
    check("bp_dataB", {224'd0, a_dn.data}, 256'hB);
    check("bp_ready1", {255'd0, a_up.ready}, 256'd1);
    check("bp_occ1b", {254'd0, occ_a}, 256'd1);
    step();
    check("bp_drained", {255'd0, a_dn.valid}, 256'd0);

    // flush while full, with a concurrent input that must vanish
    drive_a(1'b1, 32'hA, 1'b0);
    step();
    drive_a(1'b1, 32'hB, 1'b0);
    step();
    check("fl_occ2", {254'd0, occ_a}, 256'd2);
    flush = 1'b1;
    drive_a(1'b1, 32'hC, 1'b0);
    step();
    check("fl_valid_a", {255'd0, a_dn.valid}, 256'd0);
    check("fl_occ_a", {254'd0, occ_a}, 256'd0);
    check("fl_data_a", {224'd0, a_dn.data}, 256'h0);
    check("fl_ready_a", {255'd0, a_up.ready}, 256'd1);
    check("fl_valid_b", {255'd0, b_dn.valid}, 256'd0);
    check("fl_data_b", {224'd0, b_dn.data}, 256'hA);
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 1'b1);
    step();
    check("fl_noC", {255'd0, a_dn.valid}, 256'd0);

    // flush at occupancy 1 drops a same-cycle input
    drive_a(1'b1, 32'hD, 1'b0);
    step();
    flush = 1'b1;
    drive_a(1'b1, 32'hE, 1'b0);
    step();
    check("fl1_occ", {254'd0, occ_a}, 256'd0);
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0);
    step();
    check("fl1_noE", {255'd0, a_dn.valid}, 256'd0);

    // held flush accepts nothing
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 32'hF0 + 32'(i), 1'b0);
      step();
      check("flh_occ", {254'd0, occ_a}, 256'd0);
      check("flh_ready", {255'd0, a_up.ready}, 256'd1);
    end
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0);
    step();
    check("flh_after", {255'd0, a_dn.valid}, 256'd0);

    // reset wins over flush
    drive_a(1'b1, 32'h55, 1'b0);
    step();
    check("rf_loaded", {224'd0, b_dn.data}, 256'h55);
    reset = 1'b0;
    flush = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0);
    step();
    check("rf_data_b", {224'd0, b_dn.data}, 256'h12345678);
    check("rf_occ_b", {254'd0, occ_b}, 256'd0);
    check("rf_data_a", {224'd0, a_dn.data}, 256'h0);
    reset = 1'b1;
    flush = 1'b0;

    // width sweep with random traffic
    random_traffic(400, 1'b0);
    random_traffic(6, 1'b1);
    check("c_left", exp_c.size(), 256'd0);
    check("d_left", exp_d.size(), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
